// File: rtl/move_special_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : move_special_ctrl
//  Function : Hard-wired fetch/execute sequencer for mthi/mtlo, plus mfhi/mflo
//             when MOVE_FROM_SPECIAL_EN is defined (otherwise they are illegal).
//  Revision : 1.0  initial release
// ============================================================================
module move_special_ctrl #(
   parameter int unsigned READ_WAIT = 0,
   parameter logic [4:0]  OP_MFHI   = 5'b11000,
   parameter logic [4:0]  OP_MFLO   = 5'b11001,
   parameter logic [4:0]  OP_MTHI   = 5'b11100,
   parameter logic [4:0]  OP_MTLO   = 5'b11101
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [4:0] ir_op,
   output logic       PCout,
   output logic       MARin,
   output logic       IncPC,
   output logic       Read,
   output logic       MDRin,
   output logic       MDRout,
   output logic       IRin,
   output logic       Gra,
   output logic       Rin,
   output logic       Rout,
   output logic       HIin,
   output logic       LOin,
   output logic       HIout,
   output logic       LOout,
   output logic       busy,
   output logic       done,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [2:0] c_WAIT_LAST = 3'(READ_WAIT);

   state_t     r_state;
   state_t     w_next_state;
   logic [2:0] r_wait;
   logic       r_illegal_q;

   logic       w_is_mthi;
   logic       w_is_mtlo;
   logic       w_is_mfhi;
   logic       w_is_mflo;
   logic       w_legal;

   assign w_is_mthi = (ir_op == OP_MTHI);
   assign w_is_mtlo = (ir_op == OP_MTLO);

`ifdef MOVE_FROM_SPECIAL_EN
   assign w_is_mfhi = (ir_op == OP_MFHI);
   assign w_is_mflo = (ir_op == OP_MFLO);
   assign w_legal   = w_is_mthi | w_is_mtlo | w_is_mfhi | w_is_mflo;
`else
   // Move-from opcodes stay illegal even if they alias a move-to opcode.
   logic w_reserved_op;
   assign w_reserved_op = (ir_op == OP_MFHI) | (ir_op == OP_MFLO);
   assign w_is_mfhi     = 1'b0;
   assign w_is_mflo     = 1'b0;
   assign w_legal       = (w_is_mthi | w_is_mtlo) & ~w_reserved_op;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state     <= S_IDLE;
         r_wait      <= 3'd0;
         r_illegal_q <= 1'b0;
      end else begin
         r_state <= w_next_state;
         // Counter idles at zero so every T1 entry starts a fresh count.
         if (r_state == S_T1) begin
            r_wait <= r_wait + 3'd1;
         end else begin
            r_wait <= 3'd0;
         end
         if (r_state == S_T3) begin
            r_illegal_q <= ~w_legal;
         end else if (r_state == S_DONE) begin
            r_illegal_q <= 1'b0;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      PCout        = 1'b0;
      MARin        = 1'b0;
      IncPC        = 1'b0;
      Read         = 1'b0;
      MDRin        = 1'b0;
      MDRout       = 1'b0;
      IRin         = 1'b0;
      Gra          = 1'b0;
      Rin          = 1'b0;
      Rout         = 1'b0;
      HIin         = 1'b0;
      LOin         = 1'b0;
      HIout        = 1'b0;
      LOout        = 1'b0;
      done         = 1'b0;
      illegal      = 1'b0;
      busy         = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_T0;
            end
         end
         S_T0: begin
            PCout        = 1'b1;
            MARin        = 1'b1;
            w_next_state = S_T1;
         end
         S_T1: begin
            Read  = 1'b1;
            MDRin = 1'b1;
            IncPC = (r_wait == 3'd0);
            if (r_wait == c_WAIT_LAST) begin
               w_next_state = S_T2;
            end
         end
         S_T2: begin
            MDRout       = 1'b1;
            IRin         = 1'b1;
            w_next_state = S_T3;
         end
         S_T3: begin
            // Execute strobes come straight from the freshly loaded IR.
            if (w_legal) begin
               Gra   = 1'b1;
               Rout  = w_is_mthi | w_is_mtlo;
               HIin  = w_is_mthi;
               LOin  = w_is_mtlo;
               HIout = w_is_mfhi;
               LOout = w_is_mflo;
               Rin   = w_is_mfhi | w_is_mflo;
            end
            w_next_state = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            illegal      = r_illegal_q;
            w_next_state = start ? S_T0 : S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_move_special_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_move_special_ctrl
//  Function : Randomized bench for move_special_ctrl against a schedule model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_move_special_ctrl;

   localparam int unsigned c_RW      = 2;
   localparam logic [4:0]  c_OP_MFHI = 5'b11000;
   localparam logic [4:0]  c_OP_MFLO = 5'b11001;
   localparam logic [4:0]  c_OP_MTHI = 5'b11100;
   localparam logic [4:0]  c_OP_MTLO = 5'b11101;
`ifdef MOVE_FROM_SPECIAL_EN
   localparam bit c_FROM_EN = 1'b1;
`else
   localparam bit c_FROM_EN = 1'b0;
`endif

   // Phases of one instruction as seen cycle by cycle.
   localparam int P_IDLE = 0;
   localparam int P_T0   = 1;
   localparam int P_T1F  = 2;
   localparam int P_T1W  = 3;
   localparam int P_T2   = 4;
   localparam int P_T3   = 5;
   localparam int P_DONE = 6;

   typedef struct packed {
      logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Gra, Rin, Rout;
      logic HIin, LOin, HIout, LOout, busy, done, illegal;
   } outs_t;

   logic       clk = 1'b0;
   logic       clr;
   logic       start;
   logic [4:0] ir_op;
   logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Gra, Rin, Rout;
   logic HIin, LOin, HIout, LOout, busy, done, illegal;
   outs_t      w_act;

   int         n_checks = 0;
   int         n_errors = 0;
   int         q[$];
   logic [4:0] op_cur;
   logic [4:0] op_next;

   always #5 clk = ~clk;

   move_special_ctrl #(
      .READ_WAIT (c_RW),
      .OP_MFHI   (c_OP_MFHI),
      .OP_MFLO   (c_OP_MFLO),
      .OP_MTHI   (c_OP_MTHI),
      .OP_MTLO   (c_OP_MTLO)
   ) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .ir_op   (ir_op),
      .PCout   (PCout),
      .MARin   (MARin),
      .IncPC   (IncPC),
      .Read    (Read),
      .MDRin   (MDRin),
      .MDRout  (MDRout),
      .IRin    (IRin),
      .Gra     (Gra),
      .Rin     (Rin),
      .Rout    (Rout),
      .HIin    (HIin),
      .LOin    (LOin),
      .HIout   (HIout),
      .LOout   (LOout),
      .busy    (busy),
      .done    (done),
      .illegal (illegal)
   );

   assign w_act = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Gra, Rin, Rout,
                   HIin, LOin, HIout, LOout, busy, done, illegal};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit legal_op(input logic [4:0] op);
      return (op == c_OP_MTHI) || (op == c_OP_MTLO) ||
             (c_FROM_EN && ((op == c_OP_MFHI) || (op == c_OP_MFLO)));
   endfunction

   function automatic outs_t expect_outs(input int ph, input logic [4:0] op);
      outs_t e;
      e = '0;
      e.busy = (ph != P_IDLE);
      case (ph)
         P_T0:  begin e.PCout = 1'b1; e.MARin = 1'b1; end
         P_T1F: begin e.Read = 1'b1; e.MDRin = 1'b1; e.IncPC = 1'b1; end
         P_T1W: begin e.Read = 1'b1; e.MDRin = 1'b1; end
         P_T2:  begin e.MDRout = 1'b1; e.IRin = 1'b1; end
         P_T3: begin
            if (legal_op(op)) begin
               e.Gra = 1'b1;
               if (op == c_OP_MTHI) begin e.Rout = 1'b1; e.HIin = 1'b1; end
               if (op == c_OP_MTLO) begin e.Rout = 1'b1; e.LOin = 1'b1; end
               if (op == c_OP_MFHI) begin e.HIout = 1'b1; e.Rin = 1'b1; end
               if (op == c_OP_MFLO) begin e.LOout = 1'b1; e.Rin = 1'b1; end
            end
         end
         P_DONE: begin e.done = 1'b1; e.illegal = !legal_op(op); end
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic [4:0] pick_op();
      case ($urandom_range(0, 5))
         0:       return c_OP_MTHI;
         1:       return c_OP_MTLO;
         2:       return c_OP_MFHI;
         3:       return c_OP_MFLO;
         4:       return 5'b00011;
         default: return 5'($urandom);
      endcase
   endfunction

   task automatic model_advance(input bit st);
      int cur;
      cur = q.pop_front();
      if ((cur == P_IDLE || cur == P_DONE) && st) begin
         op_cur = op_next;
         q.push_back(P_T0);
         q.push_back(P_T1F);
         repeat (c_RW) q.push_back(P_T1W);
         q.push_back(P_T2);
         q.push_back(P_T3);
         q.push_back(P_DONE);
      end
      if (q.size() == 0) q.push_back(P_IDLE);
   endtask

   // One clock: drive at the falling edge, advance model at the rising edge,
   // compare shortly after.
   task automatic step(input bit st);
      @(negedge clk);
      start = st;
      if (st) op_next = pick_op();
      if (q[0] == P_T2)       ir_op = op_cur;
      else if (q[0] != P_T3)  ir_op = 5'($urandom);
      @(posedge clk);
      model_advance(st);
      #1;
      check("outs", {15'd0, w_act}, {15'd0, expect_outs(q[0], op_cur)});
   endtask

   initial begin
      int done_seen;
      int done_cyc[2];
      int n_read;
      int n_inc;
      bit reached;

      clr     = 1'b0;
      start   = 1'b0;
      ir_op   = 5'd0;
      op_cur  = 5'd0;
      op_next = 5'd0;
      q.push_back(P_IDLE);
      #1;
      check("reset_outs", {15'd0, w_act}, 32'd0);
      repeat (2) @(posedge clk);
      #1 clr = 1'b1;
      step(1'b0);

      // Held start, two back-to-back instructions.
      done_seen = 0;
      n_read    = 0;
      n_inc     = 0;
      done_cyc[0] = 0;
      done_cyc[1] = 0;
      for (int i = 1; i <= 14; i++) begin
         step(1'b1);
         if (Read)  n_read++;
         if (IncPC) n_inc++;
         if (done && done_seen < 2) begin
            done_cyc[done_seen] = i;
            done_seen++;
         end
      end
      check("done_cycle_1", done_cyc[0], 7);
      check("done_cycle_2", done_cyc[1], 14);
      check("read_cycles",  n_read, 6);
      check("incpc_cycles", n_inc, 2);
      step(1'b0);
      step(1'b0);

      // Reset asserted in the middle of T1.
      step(1'b1);
      reached = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         step(1'b0);
         if (q[0] == P_T1F || q[0] == P_T1W) reached = 1'b1;
      end
      check("reach_t1", {31'd0, reached}, 32'd1);
      #2 clr = 1'b0;
      #1;
      check("clr_async_outs", {15'd0, w_act}, 32'd0);
      q.delete();
      q.push_back(P_IDLE);
      @(posedge clk);
      #1;
      check("clr_held_outs", {15'd0, w_act}, 32'd0);
      clr = 1'b1;
      step(1'b1);
      for (int i = 0; i < 10; i++) step(1'b0);

      // Random traffic, biased toward back-to-back requests.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
